// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_ctrl_pkg : memory command encodings and SRAM arbiter state type | rev 1.0
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_D_RD    = 3'd1,
      ST_D_WR    = 3'd2,
      ST_WR_HOLD = 3'd3,
      ST_I_RD    = 3'd4
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : data/fetch sharing of one async SRAM, with pipeline stall | rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        data_ctrl,
   input  logic [15:0]       data_addr,
   input  logic [15:0]       data_wdata,
   output logic [15:0]       data_rdata,
   input  logic              inst_req,
   input  logic [15:0]       inst_addr,
   output logic [15:0]       inst_rdata,
   output logic              stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dout,
   input  logic [15:0]       sram_din,
   output logic              sram_dout_en,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              cnt_last;
   logic              data_done;
   logic              inst_done;
   logic              data_req;
   logic [ADDR_W-1:0] data_addr_x;
   logic [ADDR_W-1:0] inst_addr_x;

   // Reserved command 11 behaves exactly like NONE.
   assign data_req = (data_ctrl == MEM_READ) || (data_ctrl == MEM_WRITE);
   assign cnt_last = (cnt == CNT_LAST);
   assign stall    = (data_req && !data_done) || (inst_req && !inst_done);

   generate
      if (ADDR_W > 16) begin : g_addr_ext
         assign data_addr_x = {{(ADDR_W-16){1'b0}}, data_addr};
         assign inst_addr_x = {{(ADDR_W-16){1'b0}}, inst_addr};
      end else if (ADDR_W == 16) begin : g_addr_eq
         assign data_addr_x = data_addr;
         assign inst_addr_x = inst_addr;
      end else begin : g_addr_trunc
         assign data_addr_x = data_addr[ADDR_W-1:0];
         assign inst_addr_x = inst_addr[ADDR_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accesses always fall back to IDLE, so CE/WE deassert between any two of them.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (data_req && !data_done) begin
               state_nxt = (data_ctrl == MEM_WRITE) ? ST_D_WR : ST_D_RD;
            end else if (inst_req && !inst_done) begin
               state_nxt = ST_I_RD;
            end
         end
         ST_D_RD:    if (cnt_last) state_nxt = ST_IDLE;
         ST_I_RD:    if (cnt_last) state_nxt = ST_IDLE;
         ST_D_WR:    if (cnt_last) state_nxt = ST_WR_HOLD;
         ST_WR_HOLD: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_dout_en = 1'b0;
      case (state)
         ST_D_RD, ST_I_RD: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
         end
         ST_D_WR: begin
            sram_ce_n    = 1'b0;
            sram_we_n    = 1'b0;
            sram_dout_en = 1'b1;
         end
         ST_WR_HOLD: begin
            sram_ce_n    = 1'b0;
            sram_dout_en = 1'b1;
         end
         default: begin
            sram_ce_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= '0;
         data_done  <= 1'b0;
         inst_done  <= 1'b0;
         data_rdata <= '0;
         inst_rdata <= '0;
         sram_addr  <= '0;
         sram_dout  <= '0;
      end else begin
         if ((state == ST_IDLE) || (state == ST_WR_HOLD) || cnt_last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // Address and write data are captured once, on leaving IDLE.
         if (state == ST_IDLE) begin
            if ((state_nxt == ST_D_RD) || (state_nxt == ST_D_WR)) begin
               sram_addr <= data_addr_x;
            end else if (state_nxt == ST_I_RD) begin
               sram_addr <= inst_addr_x;
            end
            if (state_nxt == ST_D_WR) begin
               sram_dout <= data_wdata;
            end
         end

         if ((state == ST_D_RD) && cnt_last) data_rdata <= sram_din;
         if ((state == ST_I_RD) && cnt_last) inst_rdata <= sram_din;

         // The pipeline advances on every non-stalled edge, retiring both flags.
         if (!stall) begin
            data_done <= 1'b0;
            inst_done <= 1'b0;
         end else begin
            if (((state == ST_D_RD) && cnt_last) || (state == ST_WR_HOLD)) data_done <= 1'b1;
            if ((state == ST_I_RD) && cnt_last) inst_done <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single asynchronous SRAM between the CPU's instruction-fetch port (B) and data-access port (A). The block sequences SRAM strobes with a programmable wait count and serialises simultaneous requests, with data given priority over fetch. It also generates the pipeline-wide `stall` that holds the pipeline until every pending access of the current cycle has completed. It sits between `cpu` (its `MeAaddr`/`Baddr`/`MeMemControl`/`MeMemResult` signals) and the board SRAM pins.

## Interface
- `WAIT_CYCLES`, default 1: extra strobe-active cycles per access; strobe width is WAIT_CYCLES+1.
- `ADDR_W`, default 16: SRAM address width.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `data_ctrl` in 2: data-port command; `MEM_NONE`=00, `MEM_READ`=01, `MEM_WRITE`=10, 11 reserved and treated as NONE.
- `data_addr` in 16: data address.
- `data_wdata` in 16: write data.
- `data_rdata` out 16: registered read data.
- `inst_req` in 1: fetch request, level.
- `inst_addr` in 16: fetch address.
- `inst_rdata` out 16: registered instruction.
- `stall` out 1: hold the pipeline; combinational.
- `sram_addr` out ADDR_W: SRAM address; upper bits are zero-extended.
- `sram_dout` out 16: write data to SRAM.
- `sram_din` in 16: read data from SRAM.
- `sram_dout_en` out 1: tri-state drive enable.
- `sram_ce_n` out 1: SRAM chip enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- **States:** IDLE, D_RD, D_WR, WR_HOLD, I_RD.
- **Strobe counter:** `cnt` counts 0..WAIT_CYCLES.
- **Done flags:** `data_done` and `inst_done` record completion.
- **Stall equation:** `stall` = (data_ctrl∈{READ,WRITE} & !data_done) | (inst_req & !inst_done).
- **Arbitration (IDLE only):**
  - A pending data request with !data_done goes to D_RD or D_WR.
  - Otherwise a pending inst_req with !inst_done goes to I_RD.
  - Otherwise the block stays in IDLE.
  - On entry, the address and write data are latched. Input changes during an access are ignored.
- **D_RD / I_RD:**
  - ce_n=0, oe_n=0, we_n=1, for WAIT_CYCLES+1 cycles.
  - On the last cycle, `sram_din` is registered into `data_rdata` or `inst_rdata`, the matching done flag is set, and the state returns to IDLE.
- **D_WR:**
  - ce_n=0, we_n=0, oe_n=1, dout_en=1, for WAIT_CYCLES+1 cycles, then WR_HOLD.
- **WR_HOLD:**
  - ce_n=0, we_n=1, dout_en=1 for one cycle (data hold time).
  - Sets `data_done`, then returns to IDLE.
- **IDLE strobes:** ce_n=oe_n=we_n=1, dout_en=0.
- **Done-flag clearing:** at any clock edge where `stall`=0, both done flags clear, because the pipeline advances on that edge. `data_rdata` and `inst_rdata` keep their values until overwritten.
- **Reset (rst=0 at an edge):**
  - state=IDLE, cnt=0, both done flags 0, `data_rdata`=`inst_rdata`=0, `sram_addr`=0, `sram_dout`=0.
  - Strobes inactive; an access in flight is aborted.
- **Reset output values:** `stall` follows its equation. With no requests it is 0.

## Timing
- Cycle 0 = IDLE cycle in which a request is seen (W = WAIT_CYCLES).
- **Read:** strobes active cycles 1..W+1. Done flag and rdata visible cycle W+2.
- **Write:** we_n low cycles 1..W+1, hold cycle W+2. Done flag visible cycle W+3.
- **Data read + fetch in the same cycle, W=1:**
  - data read in cycles 1–2;
  - IDLE in cycle 3;
  - fetch in cycles 4–5;
  - `stall`=0 in cycle 6.
- **Fetch alone, W=1:** `stall` high cycles 0–2, low cycle 3.
- **Back-to-back accesses:** at least one IDLE cycle between any two accesses, so CE/WE always deassert between them.
- **Done-flag guard:** a request whose done flag is set is never re-served before the flags clear.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - `MEM_NONE`, `MEM_READ` and `MEM_WRITE` constants, shared with `memAddressCalculator` and `meCalResultSelector`;
  - the `arb_state_t` enum.
- No sub-module: the counter and done flags are inline.

## Test plan
- **Fetch only, W=1:** inst_req=1, inst_addr=0x0010, SRAM returns 0x4A01 → oe_n low cycles 1–2, inst_rdata=0x4A01 and stall=0 in cycle 3.
- **Simultaneous data read 0x8000 (SRAM 0x1234) and fetch 0x0011 (SRAM 0x6B02):**
  - data access in cycles 1–2, fetch in cycles 4–5;
  - data_rdata=0x1234, inst_rdata=0x6B02;
  - stall falls in cycle 6.
- **Data write, W=2:** addr 0x9000, wdata 0xBEEF → we_n low cycles 1–3, dout_en through cycle 4, stall low cycle 5, SRAM model holds 0xBEEF.
- **Held requests after completion:** data_done set while fetch is pending; data_ctrl held → no second data access occurs, and flags clear on the stall=0 edge.
- **Reserved command:** data_ctrl=11 with no fetch → stall=0, strobes stay inactive.
- **Reset mid-read:** rst=0 in cycle 1 of D_RD → next cycle IDLE, all strobes 1, rdata 0, done flags 0.
